serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 4'b1011, the 4-bit frame sync word.
REQ-002 SHALL have parameter BYTES_PER_FRAME, default 4, the data bytes per frame (legal range 1..15).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port din  input  1  serial data bit.
REQ-006 SHALL have port din_valid  input  1  qualifies din; a bit is accepted only on a cycle where din_valid=1.
REQ-007 SHALL have port out_ready  input  1  downstream consumer accepts byte_data.
REQ-008 SHALL have port byte_data  output  8  received data byte.
REQ-009 SHALL have port byte_valid  output  1  byte_data holds an unconsumed byte.
REQ-010 SHALL have port locked  output  1  high while in LOAD or PARITY.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a parity mismatch.

Function
REQ-013 SHALL implement FSM states HUNT, LOAD and PARITY.
REQ-014 In HUNT, each accepted bit SHALL shift into a 4-bit window as window <= {window[2:0], din} (newest bit at LSB).
REQ-015 HUNT SHALL go to LOAD on the accepted bit where {window[2:0], din} == SYNC_PATTERN; the bit counter, byte counter and parity accumulator SHALL clear on that transition.
REQ-016 In LOAD, accepted bits SHALL be assembled MSB-first as shift <= {shift[6:0], din}, and each bit SHALL be XORed into the parity accumulator.
REQ-017 On the 8th accepted bit of a byte, the assembled byte SHALL be offered to the output register, and the byte counter SHALL increment.
REQ-018 When the byte counter reaches BYTES_PER_FRAME, LOAD SHALL go to PARITY.
REQ-019 PARITY SHALL accept exactly one bit and then go to HUNT.
- frame_err SHALL pulse on the following cycle if (accumulator XOR bit) != 0 (even parity).
REQ-020 The window SHALL be cleared on entry to HUNT, so sync bits cannot overlap a previous frame.
REQ-021 byte_valid SHALL assert the cycle after the 8th bit is accepted, i.e. one-cycle latency.
REQ-022 Once byte_valid=1, byte_data SHALL be held stable until a cycle where byte_valid and out_ready are both 1.
REQ-023 If the output register is full and not being consumed when a byte completes, the new byte SHALL be dropped and overrun SHALL pulse.
- The held byte is retained.
- FSM progress is unaffected.
REQ-024 If a byte completes in the same cycle the held byte is consumed, the new byte SHALL load with no overrun, and byte_valid SHALL stay 1.
REQ-025 Cycles with din_valid=0 SHALL leave all FSM, window and counter state unchanged.

Reset
REQ-026 Reset SHALL be asynchronous and active-high; it SHALL force the following state, even mid-frame:
- FSM state = HUNT
- window, shift, counters, parity accumulator = 0
- byte_data = 8'h00
- byte_valid, locked, overrun, frame_err = 0
REQ-027 After reset deasserts, the first accepted bit SHALL be processed in HUNT; no partial frame SHALL resume.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration and the default sync-pattern constant.
REQ-029 The output register and its handshake SHALL be a sub-module named byte_out_buf.

Verification
REQ-030 Reset, then bits 1,0,1,1 followed by 4 bytes A5,3C,FF,00 MSB-first and parity bit 0, with out_ready=1 -> byte_valid pulses with A5,3C,FF,00 in order; locked=1 from the cycle after the 4th sync bit until after the parity bit; frame_err stays 0.
REQ-031 Same frame with parity bit 1 -> frame_err pulses exactly once, one cycle after the parity bit; all 4 bytes are still delivered.
REQ-032 out_ready=0 throughout the frame -> byte_data=A5 is held with byte_valid=1; overrun pulses 3 times; raising out_ready afterwards yields A5 only.
REQ-033 Bits 0,1,0,1,1 with din_valid toggling 1,0 every cycle -> sync is detected on the 5th valid bit; idle cycles change nothing.
REQ-034 Assert reset after 2 bits of byte 2 -> all outputs go to 0 immediately; a new sync 1011 plus frame is received correctly.
REQ-035 Byte 2 completes in the same cycle out_ready consumes byte 1 -> byte 2 is delivered, no overrun pulse.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic [3:0] DEFAULT_SYNC_PATTERN = 4'b1011;

    // Even parity: a set result means the frame's ones count was odd.
    function automatic logic even_parity_err(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/serial_frame_rx_byte_out_buf.sv
// Single-entry output holding register with ready/valid handshake and overrun flag.
module byte_out_buf (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overrun
);

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_overrun;
    logic       w_consume;
    logic       w_accept;

    assign w_consume = r_valid & i_ready;
    // A new byte fits if the slot is empty or is being drained this very cycle.
    assign w_accept  = i_load & (~r_valid | w_consume);

    // Holding register, valid flag and overrun pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load & ~w_accept;
            if (w_accept) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, assembles MSB-first bytes, checks even parity.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter logic [3:0] SYNC_PATTERN    = DEFAULT_SYNC_PATTERN,
    parameter int         BYTES_PER_FRAME = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       din,
    input  logic       din_valid,
    input  logic       out_ready,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       locked,
    output logic       overrun,
    output logic       frame_err
);

    localparam logic [3:0] LP_BYTES = 4'(BYTES_PER_FRAME);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_window, w_window_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0] r_byte_cnt, w_byte_cnt_nxt;
    logic       r_parity, w_parity_nxt;
    logic       r_locked;
    logic       r_frame_err, w_frame_err_nxt;
    logic       w_byte_done;
    logic [7:0] w_byte;

    // Next-state and datapath decode; idle cycles hold everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_window_nxt    = r_window;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_parity_nxt    = r_parity;
        w_frame_err_nxt = 1'b0;
        w_byte_done     = 1'b0;
        w_byte          = {r_shift[6:0], din};
        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    w_window_nxt = {r_window[2:0], din};
                    if ({r_window[2:0], din} == SYNC_PATTERN) begin
                        w_state_nxt    = ST_LOAD;
                        w_bit_cnt_nxt  = 3'd0;
                        w_byte_cnt_nxt = 4'd0;
                        w_parity_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_LOAD: begin
                    w_shift_nxt   = w_byte;
                    w_parity_nxt  = r_parity ^ din;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_done    = 1'b1;
                        w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                        if (r_byte_cnt + 4'd1 == LP_BYTES) begin
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_PARITY: begin
                    w_frame_err_nxt = even_parity_err(r_parity, din);
                    w_state_nxt     = ST_HUNT;
                    // Fresh window so sync cannot borrow bits from the finished frame.
                    w_window_nxt    = 4'd0;
                end
                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_window_nxt = 4'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, window, counters and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_window    <= 4'd0;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 4'd0;
            r_parity    <= 1'b0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_window    <= w_window_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_parity    <= w_parity_nxt;
            r_locked    <= (w_state_nxt != ST_HUNT);
            r_frame_err <= w_frame_err_nxt;
        end
    end

    byte_out_buf u_byte_out_buf (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_byte_done),
        .i_data    (w_byte),
        .i_ready   (out_ready),
        .o_data    (byte_data),
        .o_valid   (byte_valid),
        .o_overrun (overrun)
    );

    assign locked    = r_locked;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx against a queue-based frame model.
module tb_serial_frame_rx;

    localparam logic [3:0] SYNC = 4'b1011;
    localparam int         BPF  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       out_ready;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       locked;
    logic       overrun;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 hunting, 1 collecting data, 2 awaiting parity
    int         m_phase;
    bit         m_hq[$];
    bit         m_dq[$];
    logic [7:0] m_data;
    logic       m_valid, m_over, m_ferr;

    int         dut_over_cnt;
    int         dut_ferr_cnt;
    logic [7:0] got[$];
    logic [7:0] want[$];
    bit         frame_bits[$];

    serial_frame_rx dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .out_ready  (out_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .locked     (locked),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_phase = 0;
        m_hq.delete();
        m_dq.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic r);
        logic       done;
        logic       consume;
        logic [7:0] nb;
        logic [3:0] w;
        logic       p;
        int         n;
        consume = m_valid && r;
        done    = 1'b0;
        nb      = 8'h00;
        m_ferr  = 1'b0;
        if (v) begin
            if (m_phase == 0) begin
                m_hq.push_back(b);
                if (m_hq.size() > 4) void'(m_hq.pop_front());
                w = 4'b0000;
                foreach (m_hq[i]) w = {w[2:0], m_hq[i]};
                if (w == SYNC) begin
                    m_phase = 1;
                    m_dq.delete();
                    m_hq.delete();
                end
            end else if (m_phase == 1) begin
                m_dq.push_back(b);
                n = m_dq.size();
                if (n % 8 == 0) begin
                    done = 1'b1;
                    for (int i = 0; i < 8; i++) nb = {nb[6:0], m_dq[n-8+i]};
                end
                if (n == 8 * BPF) m_phase = 2;
            end else begin
                p = b;
                foreach (m_dq[i]) p = p ^ m_dq[i];
                m_ferr  = p;
                m_phase = 0;
                m_hq.delete();
            end
        end
        m_over = done && m_valid && !consume;
        if (done && (!m_valid || consume)) begin
            m_data  = nb;
            m_valid = 1'b1;
        end else if (consume) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance model, sample DUT 1ns after the edge.
    task automatic step(input logic b, input logic v, input logic r,
                        output logic [11:0] ov, output logic [11:0] ev);
        din       = b;
        din_valid = v;
        out_ready = r;
        if (byte_valid && out_ready) got.push_back(byte_data);
        @(posedge clock);
        model_step(b, v, r);
        #1;
        ov = {byte_valid, byte_data, locked, overrun, frame_err};
        ev = {m_valid, m_data, (m_phase != 0) ? 1'b1 : 1'b0, m_over, m_ferr};
        if (overrun)   dut_over_cnt++;
        if (frame_err) dut_ferr_cnt++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        got.delete();
        dut_over_cnt = 0;
        dut_ferr_cnt = 0;
    endtask

    task automatic make_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic flip);
        logic [31:0] all;
        all = {b0, b1, b2, b3};
        frame_bits.delete();
        frame_bits.push_back(1'b1); frame_bits.push_back(1'b0);
        frame_bits.push_back(1'b1); frame_bits.push_back(1'b1);
        for (int k = 31; k >= 0; k--) frame_bits.push_back(all[k]);
        frame_bits.push_back((^all) ^ flip);
        want.delete();
        want.push_back(b0); want.push_back(b1); want.push_back(b2); want.push_back(b3);
    endtask

    task automatic test_reset();
        logic [11:0] ov;
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; out_ready = 1'b0;
        #2;
        ov = {byte_valid, byte_data, locked, overrun, frame_err};
        total++;
        if (ov !== 12'h000) begin bad++; $display("FAIL reset_hold: got %h expected 000", ov); end
        do_reset();
        ov = {byte_valid, byte_data, locked, overrun, frame_err};
        total++;
        if (ov !== 12'h000) begin bad++; $display("FAIL reset_release: got %h expected 000", ov); end
    endtask

    task automatic test_good_frame(input logic flip, input int want_ferr);
        logic [11:0] ov, ev;
        do_reset();
        make_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, flip);
        foreach (frame_bits[i]) begin
            step(frame_bits[i], 1'b1, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL frame(flip=%0d) bit %0d: got %h expected %h", flip, i, ov, ev); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL frame_tail(flip=%0d) %0d: got %h expected %h", flip, i, ov, ev); end
        end
        total++;
        if (dut_ferr_cnt != want_ferr) begin bad++; $display("FAIL frame_err_count: got %0d expected %0d", dut_ferr_cnt, want_ferr); end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL frame_byte_count: got %0d expected 4", got.size()); end
        else begin
            foreach (want[i]) begin
                total++;
                if (got[i] !== want[i]) begin bad++; $display("FAIL frame_byte%0d: got %h expected %h", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] ov, ev;
        do_reset();
        make_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0);
        foreach (frame_bits[i]) begin
            step(frame_bits[i], 1'b1, 1'b0, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL overrun bit %0d: got %h expected %h", i, ov, ev); end
        end
        total++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
            bad++; $display("FAIL overrun_held: got v=%b d=%h expected v=1 d=a5", byte_valid, byte_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL overrun_drain %0d: got %h expected %h", i, ov, ev); end
        end
        total++;
        if (dut_over_cnt != 3) begin bad++; $display("FAIL overrun_count: got %0d expected 3", dut_over_cnt); end
        total++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            bad++; $display("FAIL overrun_delivered: got %0d bytes expected only a5", got.size());
        end
    endtask

    task automatic test_valid_gap();
        logic [11:0] ov, ev;
        logic [4:0]  pat;
        pat = 5'b01011;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL gap_valid bit %0d: got %h expected %h", 4 - i, ov, ev); end
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL gap_idle after %0d: got %h expected %h", 4 - i, ov, ev); end
        end
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL gap_locked: got %b expected 1", locked); end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] ov, ev;
        do_reset();
        make_frame(8'h5A, 8'hC3, 8'h81, 8'h7E, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(frame_bits[i], 1'b1, 1'b0, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL midreset_pre bit %0d: got %h expected %h", i, ov, ev); end
        end
        #2;
        reset = 1'b1;
        #1;
        ov = {byte_valid, byte_data, locked, overrun, frame_err};
        total++;
        if (ov !== 12'h000) begin bad++; $display("FAIL midreset_async: got %h expected 000", ov); end
        do_reset();
        foreach (frame_bits[i]) begin
            step(frame_bits[i], 1'b1, 1'b1, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL midreset_post bit %0d: got %h expected %h", i, ov, ev); end
        end
        step(1'b0, 1'b0, 1'b1, ov, ev);
        total++;
        if (got.size() != 4 || got[0] !== 8'h5A || got[3] !== 8'h7E) begin
            bad++; $display("FAIL midreset_bytes: got %0d bytes expected 4 (5a..7e)", got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ov, ev;
        do_reset();
        make_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        foreach (frame_bits[i]) begin
            step(frame_bits[i], 1'b1, (i < 4 || i >= 19) ? 1'b1 : 1'b0, ov, ev);
            total++;
            if (ov !== ev) begin bad++; $display("FAIL b2b bit %0d: got %h expected %h", i, ov, ev); end
        end
        step(1'b0, 1'b0, 1'b1, ov, ev);
        total++;
        if (dut_over_cnt != 0) begin bad++; $display("FAIL b2b_overrun: got %0d expected 0", dut_over_cnt); end
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d expected 4", got.size()); end
        else begin
            foreach (want[i]) begin
                total++;
                if (got[i] !== want[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] ov, ev;
        int          errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), ov, ev);
            total++;
            if (ov !== ev) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL random cycle %0d: got %h expected %h", i, ov, ev);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_good_frame(1'b0, 0);
        test_good_frame(1'b1, 1);
        test_overrun();
        test_valid_gap();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
